// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared types for the 4x4 keypad scanner and the downstream key evaluator.
//   kp_state_t  : scanner FSM states (SCAN, DEBOUNCE, HELD)
//   key_code_t  : packed key code {row_idx[1:0], col_idx[1:0]}
//   lowestRow() : index of the lowest-numbered active-low row
// ---------------------------------------------------------------------------
package keypad_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef logic [KEY_W-1:0] key_code_t;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    // When several rows are pulled low at once the lowest index wins, so the
    // search runs from the top row downwards and the last hit overwrites.
    function automatic logic [1:0] lowestRow(input logic [NUM_ROWS-1:0] rowN);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!rowN[r]) begin
                idx = 2'(r);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a bus of independent asynchronous level signals.
// Each bit is synchronized on its own; no coherency between bits is implied.
// Ports:
//   clk   in  1  destination clock
//   rst_n in  1  synchronous active-low reset, loads RST_VAL into both stages
//   d_i   in  W  asynchronous input
//   q_o   out W  synchronized output (two clk of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back stages; the first may go metastable, the second gives
    // it a full clock period to resolve before anything downstream looks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 matrix keypad one column at a time, debounces each press and
// release, and emits exactly one key code per press.
// Ports:
//   clk       in  1  system clock
//   rst_n     in  1  synchronous active-low reset
//   row_n     in  4  keypad rows, asynchronous, active-low, bit i = row i
//   col_n     out 4  column drive, active-low, exactly one bit low
//   key_value out 4  {row_idx, col_idx} of the last accepted key (held)
//   key_valid out 1  one-cycle strobe when key_value takes a new press
//   key_held  out 1  high from accept until the release is debounced
// Parameters:
//   SCAN_DIV       clk cycles each column is driven before it is sampled
//   DEBOUNCE_SCANS consecutive matching samples to accept a press/release
// ---------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output key_code_t key_value,
    output logic      key_valid,
    output logic      key_held
);

    localparam int DWELL_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W   = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_DONE   = DEB_W'(DEBOUNCE_SCANS);

    kp_state_t          state_q,    state_d;
    logic [1:0]         colIdx_q,   colIdx_d;
    logic [DWELL_W-1:0] dwell_q,    dwell_d;
    logic [DEB_W-1:0]   debCnt_q,   debCnt_d;
    key_code_t          cand_q,     cand_d;
    key_code_t          keyValue_q, keyValue_d;
    logic               keyValid_q, keyValid_d;
    logic               keyHeld_q,  keyHeld_d;

    logic [3:0]         rowS;
    logic               samplePoint;
    logic               rowHit;
    key_code_t          sampleCode;
    logic               candRowHigh;
    logic [DEB_W-1:0]   debNext;

    sync_2ff #(
        .W       (4),
        .RST_VAL (4'hF)
    ) u_rowSync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row_n),
        .q_o   (rowS)
    );

    // Decode of the synchronized rows at the current column. Only meaningful
    // on the sample cycle, which is the last cycle of each column dwell so the
    // synchronizer has settled on the newly driven column.
    always_comb begin
        samplePoint = (dwell_q == DWELL_LAST);
        rowHit      = |(~rowS);
        sampleCode  = {lowestRow(rowS), colIdx_q};
        candRowHigh = rowS[cand_q[3:2]];
        debNext     = debCnt_q + DEB_W'(1);
    end

    // Next-state logic. All decisions happen on the sample cycle; between
    // samples only the dwell counter moves. The dwell counter wraps at every
    // sample, which is also the only time the column or state can change.
    always_comb begin
        state_d    = state_q;
        colIdx_d   = colIdx_q;
        dwell_d    = samplePoint ? '0 : dwell_q + DWELL_W'(1);
        debCnt_d   = debCnt_q;
        cand_d     = cand_q;
        keyValue_d = keyValue_q;
        keyValid_d = 1'b0;
        keyHeld_d  = keyHeld_q;

        if (samplePoint) begin
            unique case (state_q)
                SCAN: begin
                    if (rowHit) begin
                        cand_d = sampleCode;
                        // With a single-sample debounce the first hit is
                        // already the accepting sample.
                        if (DEBOUNCE_SCANS <= 1) begin
                            keyValue_d = sampleCode;
                            keyValid_d = 1'b1;
                            keyHeld_d  = 1'b1;
                            debCnt_d   = '0;
                            state_d    = HELD;
                        end else begin
                            debCnt_d = DEB_W'(1);
                            state_d  = DEBOUNCE;
                        end
                    end else begin
                        colIdx_d = colIdx_q + 2'd1;
                    end
                end

                DEBOUNCE: begin
                    if (rowHit && (sampleCode == cand_q)) begin
                        if (debNext == DEB_DONE) begin
                            keyValue_d = cand_q;
                            keyValid_d = 1'b1;
                            keyHeld_d  = 1'b1;
                            debCnt_d   = '0;
                            state_d    = HELD;
                        end else begin
                            debCnt_d = debNext;
                        end
                    end else begin
                        debCnt_d = '0;
                        colIdx_d = colIdx_q + 2'd1;
                        state_d  = SCAN;
                    end
                end

                HELD: begin
                    // Only the accepted key's row matters here; any other key
                    // in this column is ignored until the release completes.
                    if (candRowHigh) begin
                        if (debNext == DEB_DONE) begin
                            keyHeld_d = 1'b0;
                            debCnt_d  = '0;
                            colIdx_d  = colIdx_q + 2'd1;
                            state_d   = SCAN;
                        end else begin
                            debCnt_d = debNext;
                        end
                    end else begin
                        debCnt_d = '0;
                    end
                end

                default: begin
                    debCnt_d = '0;
                    state_d  = SCAN;
                end
            endcase
        end
    end

    // State and output registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SCAN;
            colIdx_q   <= 2'd0;
            dwell_q    <= '0;
            debCnt_q   <= '0;
            cand_q     <= '0;
            keyValue_q <= '0;
            keyValid_q <= 1'b0;
            keyHeld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            colIdx_q   <= colIdx_d;
            dwell_q    <= dwell_d;
            debCnt_q   <= debCnt_d;
            cand_q     <= cand_d;
            keyValue_q <= keyValue_d;
            keyValid_q <= keyValid_d;
            keyHeld_q  <= keyHeld_d;
        end
    end

    // Column drive is a pure decode of the column register, so it is always
    // one-hot-low by construction.
    always_comb begin
        col_n = ~(4'b0001 << colIdx_q);
    end

    assign key_value = keyValue_q;
    assign key_valid = keyValid_q;
    assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3. A
// behavioural keypad pulls row r low while column c is driven low and key
// (r,c) is pressed.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_held;

    logic [3:0][3:0] pressed;

    int compareCount;
    int failCount;
    int validCount;
    int consecErr;
    int onehotErr;
    int expPulses;
    logic prevValid;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_value (key_value),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model: a pressed key shorts its row to its column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(pressed[r] & ~col_n);
        end
    end

    // Background monitor: counts strobes, flags back-to-back strobes and any
    // column drive that is not exactly one bit low.
    initial begin
        validCount = 0;
        consecErr  = 0;
        onehotErr  = 0;
        prevValid  = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) validCount++;
        if (key_valid === 1'b1 && prevValid === 1'b1) consecErr++;
        prevValid = key_valid;
        if (!(col_n inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) onehotErr++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int r, input int c, input logic down);
        @(negedge clk);
        pressed[r][c] = down;
    endtask

    task automatic waitPulse(input string tag);
        expPulses++;
        for (int i = 0; i < 300 && validCount < expPulses; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput(tag, validCount, expPulses);
    endtask

    task automatic waitHeldLow(input string tag);
        for (int i = 0; i < 120 && key_held !== 1'b0; i++) begin
            @(negedge clk);
        end
        checkOutput(tag, {31'd0, key_held}, 32'd0);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] expCol;

        compareCount = 0;
        failCount    = 0;
        expPulses    = 0;
        pressed      = '0;
        rst_n        = 1'b0;

        // 1: reset state and a full free-running column rotation.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_col_n",     {28'd0, col_n},     32'h0000000E);
        checkOutput("rst_key_value", {28'd0, key_value}, 32'd0);
        checkOutput("rst_key_valid", {31'd0, key_valid}, 32'd0);
        checkOutput("rst_key_held",  {31'd0, key_held},  32'd0);
        expCol = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            expCol = {expCol[2:0], expCol[3]};
            repeat (4) @(posedge clk);
            #1;
            checkOutput($sformatf("scan_col_%0d", k), {28'd0, col_n}, {28'd0, expCol});
        end
        checkOutput("idle_no_valid", validCount, 32'd0);

        // 2: steady press of (2,1).
        applyStimulus(2, 1, 1'b1);
        waitPulse("k21_pulse");
        checkOutput("k21_value", {28'd0, key_value}, 32'h9);
        checkOutput("k21_held",  {31'd0, key_held},  32'd1);
        idleCycles(100);
        checkOutput("k21_single", validCount, expPulses);
        applyStimulus(2, 1, 1'b0);
        idleCycles(4);
        checkOutput("k21_held_after_release", {31'd0, key_held}, 32'd1);
        waitHeldLow("k21_release");
        checkOutput("k21_value_holds", {28'd0, key_value}, 32'h9);

        // 3: (2,1) bouncing on alternate samples never produces a strobe.
        idleCycles(8);
        for (int s = 0; s < 20; s++) begin
            applyStimulus(2, 1, s[0] ? 1'b0 : 1'b1);
            repeat (3) @(negedge clk);
        end
        applyStimulus(2, 1, 1'b0);
        checkOutput("bounce_no_valid", validCount, expPulses);
        checkOutput("bounce_not_held", {31'd0, key_held}, 32'd0);
        for (int i = 0; i < 40 && col_n === 4'b0111; i++) @(negedge clk);
        for (int i = 0; i < 40 && col_n !== 4'b0111; i++) @(negedge clk);
        checkOutput("resume_reach_col3", {28'd0, col_n}, 32'h7);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("resume_wrap_col0", {28'd0, col_n}, 32'hE);

        // 4: two keys in column 0, lowest row wins; a later key is ignored.
        pressed[0][0] = 1'b1;
        applyStimulus(3, 0, 1'b1);
        waitPulse("multi_pulse");
        checkOutput("multi_value", {28'd0, key_value}, 32'h0);
        applyStimulus(1, 3, 1'b1);
        idleCycles(100);
        checkOutput("ignore_second_key", validCount, expPulses);
        checkOutput("ignore_still_held", {31'd0, key_held}, 32'd1);
        checkOutput("ignore_value",      {28'd0, key_value}, 32'h0);
        @(negedge clk);
        pressed = '0;
        waitHeldLow("multi_release");
        idleCycles(40);
        checkOutput("multi_no_extra", validCount, expPulses);

        // 5: reset while (3,3) is held; it is accepted again afterwards.
        applyStimulus(3, 3, 1'b1);
        waitPulse("k33_pulse");
        checkOutput("k33_value", {28'd0, key_value}, 32'hF);
        idleCycles(10);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_key_value", {28'd0, key_value}, 32'd0);
        checkOutput("midrst_key_held",  {31'd0, key_held},  32'd0);
        checkOutput("midrst_col_n",     {28'd0, col_n},     32'hE);
        waitPulse("k33_reaccept");
        checkOutput("k33_reaccept_value", {28'd0, key_value}, 32'hF);
        applyStimulus(3, 3, 1'b0);
        waitHeldLow("k33_release");

        // 6: (3,2) then (0,1) as separate presses.
        applyStimulus(3, 2, 1'b1);
        waitPulse("k32_pulse");
        checkOutput("k32_value", {28'd0, key_value}, 32'hE);
        applyStimulus(3, 2, 1'b0);
        waitHeldLow("k32_release");
        applyStimulus(0, 1, 1'b1);
        waitPulse("k01_pulse");
        checkOutput("k01_value", {28'd0, key_value}, 32'h1);
        checkOutput("k01_held",  {31'd0, key_held},  32'd1);
        applyStimulus(0, 1, 1'b0);
        waitHeldLow("k01_release");

        // Global properties observed over the whole run.
        checkOutput("valid_never_back_to_back", consecErr, 32'd0);
        checkOutput("col_n_always_onehot",      onehotErr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
